utf16_encoder: RTL and testbench

Downstream stage of the UTF-8 byte codec. It takes decoded code points with their error status over a valid/ready handshake and serialises each one as a UTF-16 byte stream: 2 bytes for BMP characters, 4 bytes for a surrogate pair. Invalid input is replaced with a substitution character, and a byte-order mark can be emitted once. Single clock domain; it feeds a byte sink (FIFO or UART) over a byte-wide valid/ready port.

---
 rtl/utf_pkg.sv | 23 ++
 rtl/utf16_split.sv | 41 ++++
 rtl/utf16_encoder.sv | 148 ++++++++++++++
 tb/tb_utf16_encoder.sv | 354 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/utf_pkg.sv
// Shared UTF constants, the serialiser state type and a byte-select helper
// used by the UTF-8/UTF-16 codec blocks.
package utf_pkg;

  localparam logic [31:0] UNI_MAX      = 32'h0010FFFF;
  localparam logic [31:0] SUR_LO       = 32'h0000D800;
  localparam logic [31:0] SUR_HI       = 32'h0000DFFF;
  localparam logic [15:0] BOM_CP       = 16'hFEFF;
  localparam logic [15:0] REPL_DEFAULT = 16'hFFFD;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BOM  = 2'd1,
    EMIT = 2'd2
  } state_t;

  // Big-endian sends the high byte first; little-endian sends the low byte first.
  function automatic logic [7:0] unit_byte(input logic [15:0] u, input logic be,
                                           input logic second);
    unit_byte = (be ^ second) ? u[15:8] : u[7:0];
  endfunction

endpackage

// File: rtl/utf16_split.sv
// Combinational classification of a code point into one or two UTF-16 code units,
// substituting REPL_CHAR for errored, surrogate or out-of-range values.
module utf16_split
  import utf_pkg::*;
#(
  parameter logic [15:0] REPL_CHAR = REPL_DEFAULT
) (
  input  logic [31:0] i_cp_data,
  input  logic        i_cp_error,
  output logic [15:0] o_unit0,
  output logic [15:0] o_unit1,
  output logic        o_two_units,
  output logic        o_subst
);

  logic [19:0] w_v;
  logic        w_surr;
  logic        w_range;

  // Subtracting in 20 bits is exact for every supplementary code point.
  assign w_v     = i_cp_data[19:0] - 20'h10000;
  assign w_range = i_cp_data > UNI_MAX;
  assign w_surr  = (i_cp_data >= SUR_LO) && (i_cp_data <= SUR_HI);

  always_comb begin
    o_subst     = i_cp_error || w_range || w_surr;
    o_unit0     = REPL_CHAR;
    o_unit1     = 16'h0000;
    o_two_units = 1'b0;
    if (!o_subst) begin
      if (i_cp_data < 32'h00010000) begin
        o_unit0 = i_cp_data[15:0];
      end else begin
        o_unit0     = {6'b110110, w_v[19:10]};
        o_unit1     = {6'b110111, w_v[9:0]};
        o_two_units = 1'b1;
      end
    end
  end

endmodule

// File: rtl/utf16_encoder.sv
// Serialises accepted code points as UTF-16 bytes (2 or 4 per character),
// with optional one-shot byte-order mark and a saturating substitution counter.
module utf16_encoder
  import utf_pkg::*;
#(
  parameter logic [15:0] REPL_CHAR = REPL_DEFAULT,
  parameter bit          EMIT_BOM  = 1'b0,
  parameter int          CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst_in,
  input  logic             cp_valid,
  output logic             cp_ready,
  input  logic [31:0]      cp_data,
  input  logic             cp_error,
  input  logic             be,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [7:0]       out_data,
  output logic             out_last,
  output logic             replaced,
  output logic [CNT_W-1:0] repl_count,
  output logic [1:0]       dbg_state
);

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t           r_state;
  logic [15:0]      r_unit0;
  logic [15:0]      r_unit1;
  logic             r_two;
  logic             r_be;
  logic             r_bom_pend;
  logic [1:0]       r_cnt;
  logic             r_out_valid;
  logic [7:0]       r_out_data;
  logic             r_out_last;
  logic             r_replaced;
  logic [CNT_W-1:0] r_repl_count;

  logic [15:0] w_unit0;
  logic [15:0] w_unit1;
  logic        w_two;
  logic        w_subst;
  logic        w_accept;
  logic        w_xfer;
  logic [1:0]  w_last_idx;
  logic [1:0]  w_next_cnt;
  logic [15:0] w_next_unit;

  utf16_split #(.REPL_CHAR(REPL_CHAR)) u_split (
    .i_cp_data   (cp_data),
    .i_cp_error  (cp_error),
    .o_unit0     (w_unit0),
    .o_unit1     (w_unit1),
    .o_two_units (w_two),
    .o_subst     (w_subst)
  );

  // Both ports: a transfer happens on a rising edge where valid & ready are high;
  // a producer holding valid keeps its data stable and never drops valid before that.
  assign cp_ready    = rst_in && (r_state == IDLE);
  assign w_accept    = cp_valid && cp_ready;
  assign w_xfer      = r_out_valid && out_ready;
  assign w_last_idx  = r_two ? 2'd3 : 2'd1;
  assign w_next_cnt  = r_cnt + 2'd1;
  assign w_next_unit = w_next_cnt[1] ? r_unit1 : r_unit0;

  always_ff @(posedge clk or negedge rst_in) begin
    if (!rst_in) begin
      r_state      <= IDLE;
      r_unit0      <= 16'h0000;
      r_unit1      <= 16'h0000;
      r_two        <= 1'b0;
      r_be         <= 1'b0;
      r_bom_pend   <= EMIT_BOM;
      r_cnt        <= 2'd0;
      r_out_valid  <= 1'b0;
      r_out_data   <= 8'h00;
      r_out_last   <= 1'b0;
      r_replaced   <= 1'b0;
      r_repl_count <= '0;
    end else begin
      r_replaced <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_unit0     <= w_unit0;
            r_unit1     <= w_unit1;
            r_two       <= w_two;
            r_be        <= be;
            r_cnt       <= 2'd0;
            r_out_valid <= 1'b1;
            r_out_last  <= 1'b0;
            if (r_bom_pend) begin
              r_state    <= BOM;
              r_out_data <= unit_byte(BOM_CP, be, 1'b0);
            end else begin
              r_state    <= EMIT;
              r_out_data <= unit_byte(w_unit0, be, 1'b0);
            end
            if (w_subst) begin
              r_replaced <= 1'b1;
              if (r_repl_count != '1) r_repl_count <= r_repl_count + CNT_ONE;
            end
          end
        end
        BOM: begin
          if (w_xfer) begin
            if (r_cnt == 2'd0) begin
              r_cnt      <= 2'd1;
              r_out_data <= unit_byte(BOM_CP, r_be, 1'b1);
            end else begin
              r_cnt      <= 2'd0;
              r_bom_pend <= 1'b0;
              r_state    <= EMIT;
              r_out_data <= unit_byte(r_unit0, r_be, 1'b0);
            end
          end
        end
        EMIT: begin
          if (w_xfer) begin
            if (r_cnt == w_last_idx) begin
              r_state     <= IDLE;
              r_cnt       <= 2'd0;
              r_out_valid <= 1'b0;
              r_out_data  <= 8'h00;
              r_out_last  <= 1'b0;
            end else begin
              r_cnt      <= w_next_cnt;
              r_out_data <= unit_byte(w_next_unit, r_be, w_next_cnt[0]);
              r_out_last <= (w_next_cnt == w_last_idx);
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign out_valid  = r_out_valid;
  assign out_data   = r_out_data;
  assign out_last   = r_out_last;
  assign replaced   = r_replaced;
  assign repl_count = r_repl_count;
  assign dbg_state  = r_state;

endmodule

// File: tb/tb_utf16_encoder.sv
// Bench for utf16_encoder: a plain instance and a BOM instance with a narrow counter,
// checked every cycle against a queue-based byte model plus literal byte sequences.
module tb_utf16_encoder;

  logic        clk    = 1'b0;
  logic        rst_in = 1'b0;
  logic [1:0]  cp_valid  = 2'b00;
  logic [1:0]  cp_error  = 2'b00;
  logic [1:0]  be        = 2'b00;
  logic [1:0]  out_ready = 2'b00;
  logic [31:0] cp_data [2];

  wire [1:0]  cp_ready, out_valid, out_last, replaced;
  wire [7:0]  out_data0, out_data1;
  wire [15:0] rc0;
  wire [2:0]  rc1;
  wire [1:0]  dbg0, dbg1;

  int checks = 0;
  int errors = 0;

  logic [8:0] exp_q0[$], exp_q1[$];
  logic [8:0] got_q0[$], got_q1[$];
  logic [8:0] lit_q[$];

  bit          acc_prev[2];
  bit          subst_prev[2];
  bit          bom_pend[2];
  int unsigned cnt_m[2];
  int          rdy_mode[2];

  utf16_encoder #(.EMIT_BOM(1'b0), .CNT_W(16)) u_dut (
    .clk(clk), .rst_in(rst_in), .cp_valid(cp_valid[0]), .cp_ready(cp_ready[0]),
    .cp_data(cp_data[0]), .cp_error(cp_error[0]), .be(be[0]),
    .out_valid(out_valid[0]), .out_ready(out_ready[0]), .out_data(out_data0),
    .out_last(out_last[0]), .replaced(replaced[0]), .repl_count(rc0), .dbg_state(dbg0)
  );

  utf16_encoder #(.EMIT_BOM(1'b1), .CNT_W(3)) u_dut_bom (
    .clk(clk), .rst_in(rst_in), .cp_valid(cp_valid[1]), .cp_ready(cp_ready[1]),
    .cp_data(cp_data[1]), .cp_error(cp_error[1]), .be(be[1]),
    .out_valid(out_valid[1]), .out_ready(out_ready[1]), .out_data(out_data1),
    .out_last(out_last[1]), .replaced(replaced[1]), .repl_count(rc1), .dbg_state(dbg1)
  );

  // ---------------- clock / watchdog ----------------
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, errors so far %0d", errors);
    $fatal(1);
  end

  // ---------------- checking helpers ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int q_size(input int k);
    return (k == 0) ? exp_q0.size() : exp_q1.size();
  endfunction

  function automatic int unsigned cnt_max(input int k);
    return (k == 0) ? 32'd65535 : 32'd7;
  endfunction

  // Reference: UTF-16 bytes for one character, from the encoding rules.
  task automatic model_char(input int k, input logic [31:0] cp, input logic err,
                            input logic b);
    logic [31:0] units[$];
    bit          fins[$];
    logic [31:0] off, hb, lb;
    logic [8:0]  e;
    bit          sub;
    sub = err || (cp > 32'h10FFFF) || (cp >= 32'hD800 && cp <= 32'hDFFF);
    if (bom_pend[k]) begin
      units.push_back(32'hFEFF);
      fins.push_back(1'b0);
      bom_pend[k] = 1'b0;
    end
    if (sub) begin
      units.push_back(32'hFFFD);
      fins.push_back(1'b1);
    end else if (cp < 32'd65536) begin
      units.push_back(cp);
      fins.push_back(1'b1);
    end else begin
      off = cp - 32'd65536;
      units.push_back(32'hD800 + off / 1024);
      fins.push_back(1'b0);
      units.push_back(32'hDC00 + off % 1024);
      fins.push_back(1'b1);
    end
    foreach (units[i]) begin
      hb = units[i] / 256;
      lb = units[i] % 256;
      for (int j = 0; j < 2; j++) begin
        if ((j == 0) == b) e = {1'b0, hb[7:0]};
        else               e = {1'b0, lb[7:0]};
        if (j == 1) e[8] = fins[i];
        if (k == 0) exp_q0.push_back(e);
        else        exp_q1.push_back(e);
      end
    end
    subst_prev[k] = sub;
    if (sub && cnt_m[k] < cnt_max(k)) cnt_m[k]++;
  endtask

  task automatic step(input int k, input logic rdy, input logic ov, input logic ordy,
                      input logic [7:0] od, input logic ol, input logic rp,
                      input logic [15:0] rc, input logic cv, input logic [31:0] cd,
                      input logic ce, input logic cb);
    logic [8:0] h;
    if (!rst_in) begin
      chk($sformatf("rst_out_valid%0d", k), ov, 1'b0);
      chk($sformatf("rst_cp_ready%0d", k), rdy, 1'b0);
      chk($sformatf("rst_out_data%0d", k), od, 8'h00);
      chk($sformatf("rst_out_last%0d", k), ol, 1'b0);
      chk($sformatf("rst_replaced%0d", k), rp, 1'b0);
      chk($sformatf("rst_repl_count%0d", k), rc, 16'h0);
      if (k == 0) exp_q0.delete();
      else        exp_q1.delete();
      cnt_m[k]    = 0;
      acc_prev[k] = 1'b0;
      bom_pend[k] = (k == 1);
    end else begin
      chk($sformatf("cp_ready%0d", k), rdy, q_size(k) == 0);
      chk($sformatf("replaced%0d", k), rp, acc_prev[k] && subst_prev[k]);
      chk($sformatf("repl_count%0d", k), rc, cnt_m[k]);
      if (acc_prev[k]) chk($sformatf("latency%0d", k), ov, 1'b1);
      if (ov) begin
        if (q_size(k) == 0) begin
          chk($sformatf("extra_byte%0d", k), {ol, od}, 9'h000);
          chk($sformatf("unexpected_valid%0d", k), ov, 1'b0);
        end else begin
          h = (k == 0) ? exp_q0[0] : exp_q1[0];
          chk($sformatf("out_data%0d", k), od, h[7:0]);
          chk($sformatf("out_last%0d", k), ol, h[8]);
          if (ordy) begin
            if (k == 0) begin
              void'(exp_q0.pop_front());
              got_q0.push_back({ol, od});
            end else begin
              void'(exp_q1.pop_front());
              got_q1.push_back({ol, od});
            end
          end
        end
      end
      acc_prev[k] = 1'b0;
      if (cv && rdy) begin
        acc_prev[k] = 1'b1;
        model_char(k, cd, ce, cb);
      end
    end
  endtask

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    step(0, cp_ready[0], out_valid[0], out_ready[0], out_data0, out_last[0], replaced[0],
         rc0, cp_valid[0], cp_data[0], cp_error[0], be[0]);
    step(1, cp_ready[1], out_valid[1], out_ready[1], out_data1, out_last[1], replaced[1],
         {13'b0, rc1}, cp_valid[1], cp_data[1], cp_error[1], be[1]);
  end

  // ---------------- sink-side ready driver ----------------
  initial begin
    forever begin
      @(posedge clk);
      #1;
      for (int k = 0; k < 2; k++) begin
        case (rdy_mode[k])
          0:       out_ready[k] = 1'b1;
          1:       out_ready[k] = ~out_ready[k];
          default: out_ready[k] = 1'($urandom_range(0, 1));
        endcase
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    rst_in = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_in = 1'b1;
  endtask

  task automatic send(input int k, input logic [31:0] cp, input logic err, input logic b);
    bit done;
    done = 1'b0;
    cp_data[k]  = cp;
    cp_error[k] = err;
    be[k]       = b;
    cp_valid[k] = 1'b1;
    for (int n = 0; n < 300 && !done; n++) begin
      @(negedge clk);
      if (cp_ready[k]) done = 1'b1;
    end
    if (done) begin
      @(posedge clk);
      #1;
    end else begin
      chk($sformatf("accept_timeout%0d", k), done, 1'b1);
    end
    cp_valid[k] = 1'b0;
    be[k]       = 1'($urandom_range(0, 1));
    cp_data[k]  = $urandom;
    cp_error[k] = 1'($urandom_range(0, 1));
  endtask

  task automatic wait_idle(input int k);
    bit idle;
    idle = 1'b0;
    for (int n = 0; n < 400 && !idle; n++) begin
      @(posedge clk);
      #2;
      if (out_valid[k] == 1'b0 && q_size(k) == 0) idle = 1'b1;
    end
    chk($sformatf("drain%0d", k), idle, 1'b1);
  endtask

  task automatic clear_got(input int k);
    if (k == 0) got_q0.delete();
    else        got_q1.delete();
  endtask

  task automatic check_seq(input int k, input string name);
    logic [8:0] g[$];
    if (k == 0) g = got_q0;
    else        g = got_q1;
    chk({name, "_len"}, g.size(), lit_q.size());
    foreach (lit_q[i]) begin
      if (i < g.size()) chk($sformatf("%s_b%0d", name, i), g[i], lit_q[i]);
    end
  endtask

  function automatic logic [31:0] rand_cp();
    logic [31:0] edges[8];
    edges = '{32'hFFFF, 32'h10000, 32'h10FFFF, 32'h110000,
              32'hD7FF, 32'hE000, 32'hD800, 32'hDFFF};
    case ($urandom_range(0, 7))
      0:       return $urandom_range(0, 127);
      1:       return $urandom_range(128, 32'hD7FF);
      2:       return $urandom_range(32'hD800, 32'hDFFF);
      3:       return $urandom_range(32'hE000, 32'hFFFF);
      4:       return $urandom_range(32'h10000, 32'h10FFFF);
      5:       return 32'h110000 + $urandom_range(0, 32'h00FFFFFF);
      6:       return 32'hF0000000 | ($urandom & 32'h0FFFFFFF);
      default: return edges[$urandom_range(0, 7)];
    endcase
  endfunction

  // ---------------- main sequence ----------------
  initial begin
    cp_data[0]  = 32'h0;
    cp_data[1]  = 32'h0;
    rdy_mode[0] = 0;
    rdy_mode[1] = 0;
    repeat (3) @(posedge clk);
    #1;
    rst_in = 1'b1;
    @(posedge clk);
    #1;

    // ASCII, little-endian
    clear_got(0);
    send(0, 32'h41, 1'b0, 1'b0);
    wait_idle(0);
    lit_q = {9'h041, 9'h100};
    check_seq(0, "ascii_le");

    // Surrogate pair, big-endian
    clear_got(0);
    send(0, 32'h1F600, 1'b0, 1'b1);
    wait_idle(0);
    lit_q = {9'h0D8, 9'h03D, 9'h0DE, 9'h100};
    check_seq(0, "pair_be");

    // Three substitutions
    clear_got(0);
    send(0, 32'hD800, 1'b0, 1'b1);
    send(0, 32'h110000, 1'b0, 1'b1);
    send(0, 32'h20AC, 1'b1, 1'b1);
    wait_idle(0);
    lit_q = {9'h0FF, 9'h1FD, 9'h0FF, 9'h1FD, 9'h0FF, 9'h1FD};
    check_seq(0, "subst3");
    chk("repl_count_after3", rc0, 16'd3);

    // Stalled sink toggling every cycle
    rdy_mode[0] = 1;
    clear_got(0);
    send(0, 32'h10000, 1'b0, 1'b0);
    wait_idle(0);
    lit_q = {9'h000, 9'h0D8, 9'h000, 9'h1DC};
    check_seq(0, "pair_stall");
    rdy_mode[0] = 0;

    // Reset after the second byte of a pair
    clear_got(0);
    send(0, 32'h1F600, 1'b0, 1'b1);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_in = 1'b0;
    #1;
    chk("midrst_out_valid", out_valid[0], 1'b0);
    chk("midrst_repl_count", rc0, 16'd0);
    lit_q = {9'h0D8, 9'h03D};
    check_seq(0, "midrst_partial");
    repeat (2) @(posedge clk);
    #1;
    rst_in = 1'b1;
    clear_got(0);
    send(0, 32'h41, 1'b0, 1'b0);
    wait_idle(0);
    lit_q = {9'h041, 9'h100};
    check_seq(0, "after_rst");

    // Byte-order mark once, then plain characters
    clear_got(1);
    send(1, 32'hE9, 1'b0, 1'b0);
    send(1, 32'h42, 1'b0, 1'b0);
    wait_idle(1);
    lit_q = {9'h0FF, 9'h0FE, 9'h0E9, 9'h100, 9'h042, 9'h100};
    check_seq(1, "bom_once");

    // Narrow counter saturation
    for (int i = 0; i < 9; i++) send(1, 32'hDC00 + i, 1'b0, 1'($urandom_range(0, 1)));
    wait_idle(1);
    chk("repl_count_sat", {13'b0, rc1}, 16'd7);

    // Randomized traffic with random back-pressure and occasional resets
    for (int k = 0; k < 2; k++) begin
      rdy_mode[k] = 2;
      for (int i = 0; i < 150; i++) begin
        send(k, rand_cp(), ($urandom_range(0, 7) == 0), 1'($urandom_range(0, 1)));
        if ($urandom_range(0, 49) == 0) do_reset();
      end
      wait_idle(k);
      rdy_mode[k] = 0;
    end

    repeat (4) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
